fetch_queue: RTL and testbench

//  Instruction-fetch stage between the PC register and decode. Takes the current PC,

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fq_fifo.sv | 57 +++++
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch queue.
package fetch_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response and decode-side valid/ready bundle.
interface fetch_queue_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/fq_fifo.sv
// Synchronous FIFO with clear, full/empty flags and occupancy count.
module fq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && !clr && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is not reset; contents are only observed through count/empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order imem requests, tags responses with their PC, queues them for decode.
// Optional FETCH_QUEUE_PERF_EN adds saturating stall/flush cycle counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_stall,
  input  logic            flush,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  fetch_queue_if.master   bus
);
  localparam int QW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;

  logic [QW-1:0]   q_count;
  logic            q_full, q_empty, q_pop;
  fq_entry_t       q_wdata, q_head;
  logic [OW-1:0]   out_cnt, drop_cnt;
  logic            tag_full, tag_empty;
  logic [XLEN-1:0] tag_head;
  logic [31:0]     used;
  logic            credit, issue, rsp, keep;

  // A slot popped by decode this cycle is already available for a new request.
  assign q_pop  = !q_empty && bus.id_ready;
  assign used   = 32'(q_count) - 32'(q_pop) + 32'(out_cnt);
  assign credit = (used < 32'(DEPTH)) && !tag_full;

  assign bus.imem_req  = credit && !flush && rst_n;
  assign bus.imem_addr = word_addr(pc_in);
  assign issue         = bus.imem_req && bus.imem_gnt;
  assign fetch_stall   = !issue;
  assign pc_plus4      = pc_in + 32'd4;

  // Words for requests issued before a flush are consumed here without entering the queue.
  assign rsp     = bus.imem_rvalid && !tag_empty;
  assign keep    = rsp && (drop_cnt == '0) && !flush;
  assign q_wdata = '{pc: tag_head, instr: bus.imem_rdata};

  fq_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .pop   (rsp),
    .clr   (1'b0),
    .wdata (pc_in),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (out_cnt)
  );

  fq_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_dec_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .pop   (q_pop),
    .clr   (flush),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      drop_cnt <= '0;
    else if (flush)                  drop_cnt <= out_cnt - OW'(rsp);
    else if (rsp && drop_cnt != '0)  drop_cnt <= drop_cnt - 1'b1;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    bus.id_valid = 1'b0;
    bus.id_instr = NOP_INSTR;
    bus.id_pc    = '0;
    if (!q_empty) begin
      bus.id_valid = 1'b1;
      bus.id_instr = q_head.instr;
      bus.id_pc    = q_head.pc;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush && perf_flush_cnt != '1)       perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (out_cnt != '0));
  a_queue_has_slot: assert property (
    @(posedge clk) disable iff (!rst_n) keep |-> (!q_full || q_pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, MAX_OUT=2).
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [31:0] pc_plus4;
  logic        fetch_stall;
  logic        flush;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_plus4       (pc_plus4),
    .fetch_stall    (fetch_stall),
    .flush          (flush),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_reg;
  logic [31:0] redirect_pc;
  logic [31:0] pend[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_id(input logic v, input logic [31:0] pc, input string tag);
    check({tag, "_valid"}, 32'(bus.id_valid), 32'(v));
    check({tag, "_pc"},    bus.id_pc,    v ? pc : 32'h0);
    check({tag, "_instr"}, bus.id_instr, v ? instr_of(pc) : 32'h0);
  endtask

  // One clock cycle, entered and left at the falling edge; memory answers from pend.
  task automatic cyc(input logic g, input logic rv, input logic rdy, input logic fl,
                     input logic exp_req, input string tag);
    logic        resp;
    logic        fire;
    logic [31:0] addr_q;
    resp             = rv && (pend.size() > 0);
    bus.imem_gnt     = g;
    bus.imem_rvalid  = resp;
    bus.imem_rdata   = resp ? instr_of(pend[0]) : 32'h0;
    bus.id_ready     = rdy;
    flush            = fl;
    pc_in            = pc_reg;
    #1;
    check({tag, "_req"},   32'(bus.imem_req), 32'(exp_req));
    check({tag, "_stall"}, 32'(fetch_stall),  32'(!(exp_req && g)));
    if (exp_req) check({tag, "_addr"}, bus.imem_addr, {pc_reg[31:2], 2'b00});
    fire   = bus.imem_req && g;
    addr_q = bus.imem_addr;
    @(posedge clk);
    if (fire) pend.push_back(addr_q);
    if (resp) void'(pend.pop_front());
    if (fl)        pc_reg = redirect_pc;
    else if (fire) pc_reg = pc_reg + 32'd4;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    flush           = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] t5_pc [5] = '{32'h0090_0004, 32'hFFFF_FFFC, 32'h1234_5679, 32'h7FFF_FFFC, 32'h0000_0000};
  logic [31:0] t5_p4 [5] = '{32'h0090_0008, 32'h0000_0000, 32'h1234_567D, 32'h8000_0000, 32'h0000_0004};

  initial begin
    rst_n = 1'b0; pc_in = '0; flush = 1'b0; redirect_pc = '0; pc_reg = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req",   32'(bus.imem_req), 32'h0);
    check("rst_stall", 32'(fetch_stall),  32'h1);
    check("rst_p4",    pc_plus4,          32'h0000_0004);
    expect_id(1'b0, 32'h0, "rst");
`ifdef FETCH_QUEUE_PERF_EN
    check("rst_perf_stall", perf_stall_cnt, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 1: streaming, one word per cycle.
    pc_reg = 32'h0040_0000; pc_in = pc_reg; #1;
    check("t1_p4", pc_plus4, 32'h0040_0004);
    cyc(1, 0, 1, 0, 1, "t1_c0");
    expect_id(1'b0, 32'h0, "t1_lat");
    cyc(1, 1, 1, 0, 1, "t1_c1");
    for (int i = 0; i < 4; i++) begin
      expect_id(1'b1, 32'h0040_0000 + 32'(4 * i), "t1_stream");
      cyc(1, 1, 1, 0, 1, "t1_s");
    end
    expect_id(1'b1, 32'h0040_0010, "t1_d0");
    cyc(0, 1, 1, 0, 1, "t1_d0");
    expect_id(1'b1, 32'h0040_0014, "t1_d1");
    cyc(0, 0, 1, 0, 1, "t1_d1");
    expect_id(1'b0, 32'h0, "t1_empty");

    // 2: decode stalled until the queue is full, then drains in order.
    cyc(1, 0, 0, 0, 1, "t2_c0");
    cyc(1, 1, 0, 0, 1, "t2_c1");
    cyc(1, 1, 0, 0, 1, "t2_c2");
    cyc(1, 1, 0, 0, 1, "t2_c3");
    cyc(1, 1, 0, 0, 0, "t2_full");
    cyc(1, 0, 0, 0, 0, "t2_hold");
    for (int i = 0; i < 4; i++) begin
      expect_id(1'b1, 32'h0040_0018 + 32'(4 * i), "t2_drain");
      cyc(0, 0, 1, 0, 1, "t2_pop");
    end
    expect_id(1'b0, 32'h0, "t2_empty");

    // 3: flush with two requests in flight.
    cyc(1, 0, 1, 0, 1, "t3_c0");
    cyc(1, 0, 1, 0, 1, "t3_c1");
    redirect_pc = 32'h0080_0000;
    cyc(1, 0, 1, 1, 0, "t3_flush");
    check("t3_drop2", 32'(dut.drop_cnt), 32'd2);
    cyc(1, 1, 1, 0, 0, "t3_r0");
    check("t3_drop1", 32'(dut.drop_cnt), 32'd1);
    expect_id(1'b0, 32'h0, "t3_r0");
    cyc(1, 1, 1, 0, 1, "t3_r1");
    check("t3_drop0", 32'(dut.drop_cnt), 32'd0);
    expect_id(1'b0, 32'h0, "t3_r1");
    cyc(0, 1, 1, 0, 1, "t3_r2");
    expect_id(1'b1, 32'h0080_0000, "t3_new");
    cyc(0, 0, 1, 0, 1, "t3_pop");
    expect_id(1'b0, 32'h0, "t3_empty");

    // 4: flush coincides with the only outstanding response; queued word also killed.
    cyc(1, 0, 1, 0, 1, "t4_c0");
    cyc(1, 1, 0, 0, 1, "t4_c1");
    expect_id(1'b1, 32'h0080_0004, "t4_q");
    redirect_pc = 32'h0090_0000;
    cyc(1, 1, 0, 1, 0, "t4_flush");
    check("t4_drop", 32'(dut.drop_cnt), 32'd0);
    check("t4_out",  32'(dut.out_cnt),  32'd0);
    expect_id(1'b0, 32'h0, "t4_flushed");
    cyc(1, 0, 1, 0, 1, "t4_refetch");
    cyc(0, 1, 1, 0, 1, "t4_rsp");
    expect_id(1'b1, 32'h0090_0000, "t4_new");
    cyc(0, 0, 1, 0, 1, "t4_pop");
    expect_id(1'b0, 32'h0, "t4_empty");

    // 5: grant withheld; stall every cycle, pc_plus4 follows pc_in including wrap.
    for (int i = 0; i < 5; i++) begin
      pc_reg = t5_pc[i]; pc_in = pc_reg; #1;
      check("t5_p4", pc_plus4, t5_p4[i]);
      cyc(0, 0, 1, 0, 1, "t5");
    end
    check("t5_out", 32'(dut.out_cnt), 32'd0);

    // 6: reset mid-stream.
    pc_reg = 32'h00A0_0000;
    cyc(1, 0, 0, 0, 1, "t6_c0");
    cyc(1, 1, 0, 0, 1, "t6_c1");
    expect_id(1'b1, 32'h00A0_0000, "t6_pre");
    rst_n = 1'b0; bus.imem_gnt = 1'b0; bus.id_ready = 1'b0; #1;
    check("t6_valid", 32'(bus.id_valid), 32'h0);
    check("t6_req",   32'(bus.imem_req), 32'h0);
    check("t6_stall", 32'(fetch_stall),  32'h1);
`ifdef FETCH_QUEUE_PERF_EN
    check("t6_perf_stall", perf_stall_cnt, 32'h0);
    check("t6_perf_flush", perf_flush_cnt, 32'h0);
`endif
    pend.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_out",  32'(dut.out_cnt),  32'd0);
    check("t6_drop", 32'(dut.drop_cnt), 32'd0);
    expect_id(1'b0, 32'h0, "t6_post");
    pc_reg = 32'h00B0_0000;
    cyc(1, 0, 1, 0, 1, "t6_c2");
    cyc(0, 1, 1, 0, 1, "t6_c3");
    expect_id(1'b1, 32'h00B0_0000, "t6_new");
    cyc(0, 0, 1, 0, 1, "t6_c4");
    expect_id(1'b0, 32'h0, "t6_empty");
    redirect_pc = 32'h00C0_0000;
    cyc(0, 0, 1, 1, 0, "t6_flush");
`ifdef FETCH_QUEUE_PERF_EN
    check("t6_perf_stall_n", perf_stall_cnt, 32'd3);
    check("t6_perf_flush_n", perf_flush_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
